cpu_ctrl: RTL and testbench

//  Multi-cycle fetch/decode/execute controller of the 8-bit CPU; drives the alu

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/cpu_ctrl_regfile.sv | 32 +++
 rtl/cpu_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU controller: opcodes, FSM states, instruction fields.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // Instruction word layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 8;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  // Opcodes; AND..LTI is the contiguous defined range, 4'hF is undefined
  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_CMP   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h6;
  localparam logic [3:0] OP_CMPI  = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JMPR  = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_LI    = 4'hD;
  localparam logic [3:0] OP_LTI   = 4'hE;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_LTI);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == OP_CMP) || (op == OP_CMPI) || (op == OP_LTI);
  endfunction

  // Every defined op writes rd except control transfers and stores
  function automatic logic op_writes_rd(input logic [3:0] op);
    return op_defined(op) && (op != OP_JMP) && (op != OP_JMPR) &&
           (op != OP_JNZ) && (op != OP_STORE);
  endfunction

endpackage

// File: rtl/cpu_ctrl_regfile.sv
// 4x8 register file: two asynchronous read ports (rs, rd), one synchronous write port.
// Latency: reads combinational; write visible the cycle after we_i.
// Backpressure: none; synchronous active-low clear overrides writes.
module cpu_ctrl_regfile
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] rs_addr_i,
  input  logic [1:0] rd_addr_i,
  output logic [7:0] rs_data_o,
  output logic [7:0] rd_data_o
);

  logic [7:0] regs_q [4];

  // Register storage with synchronous clear and single write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o = regs_q[rs_addr_i];
  assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller driving an external alu and imem/dmem.
// Latency: 4 cycles/instr with zero-wait memories, 5 for LOAD/STORE, +1 per wait cycle.
// Backpressure: req held with stable address/data until ack; acks with req low are ignored.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_in0,
  output logic [7:0]  alu_in1,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  output logic [7:0]  pc,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  res_q, res_d;
  logic        flag_q, flag_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        halted_q, halted_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_in0_q, alu_in0_d;
  logic [7:0]  alu_in1_q, alu_in1_d;

  logic [3:0]  op;
  logic [1:0]  rd_sel;
  logic [1:0]  rs_sel;
  logic [7:0]  imm;
  logic [7:0]  rs_data;
  logic [7:0]  rd_data;
  logic        rf_we;

  assign op     = ir_q[OP_HI:OP_LO];
  assign rd_sel = ir_q[RD_HI:RD_LO];
  assign rs_sel = ir_q[RS_HI:RS_LO];
  assign imm    = ir_q[IMM_HI:IMM_LO];

  cpu_ctrl_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd_sel),
    .wdata_i   (res_q),
    .rs_addr_i (rs_sel),
    .rd_addr_i (rd_sel),
    .rs_data_o (rs_data),
    .rd_data_o (rd_data)
  );

  // State and datapath registers; requests are registered so reset drops them next edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_RESET;
      ir_q       <= 16'h0000;
      res_q      <= 8'h00;
      flag_q     <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      alu_op_q   <= 4'h0;
      alu_in0_q  <= 8'h00;
      alu_in1_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
      alu_op_q   <= alu_op_d;
      alu_in0_q  <= alu_in0_d;
      alu_in1_q  <= alu_in1_d;
    end
  end

  // Next-state and datapath updates for each FSM phase
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    res_d      = res_q;
    flag_d     = flag_q;
    imem_req_d = imem_req_q;
    dmem_req_d = dmem_req_q;
    dmem_we_d  = dmem_we_q;
    halted_d   = halted_q;
    alu_op_d   = alu_op_q;
    alu_in0_d  = alu_in0_q;
    alu_in1_d  = alu_in1_q;
    rf_we      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // Right after reset the request is still low; raise it and wait for the ack
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_data;
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end

      ST_DECODE: begin
        if (!op_defined(op)) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          alu_op_d = op;
          case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_CMP: begin
              alu_in0_d = rs_data;
              alu_in1_d = rd_data;
            end
            OP_ADDI, OP_SUBI, OP_CMPI, OP_LTI: begin
              alu_in0_d = imm;
              alu_in1_d = rd_data;
            end
            OP_LOAD, OP_STORE: begin
              alu_in0_d = imm;
              alu_in1_d = rs_data;
            end
            OP_JMPR: begin
              alu_in0_d = imm;
              alu_in1_d = pc_q;
            end
            default: begin  // JMP, JNZ, LI pass the immediate through
              alu_in0_d = imm;
              alu_in1_d = 8'h00;
            end
          endcase
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        res_d = alu_out;
        if (op_is_cmp(op)) flag_d = alu_zf;
        if (op_is_mem(op)) begin
          dmem_req_d = 1'b1;
          dmem_we_d  = (op == OP_STORE);
          state_d    = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (!dmem_we_q) res_d = dmem_rdata;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = ST_WB;
        end
      end

      ST_WB: begin
        rf_we = op_writes_rd(op);
        if ((op == OP_JMP) || (op == OP_JMPR) || ((op == OP_JNZ) && flag_q)) begin
          pc_d = res_q;
        end else begin
          pc_d = pc_q + 8'd1;
        end
        imem_req_d = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = res_q;
  assign dmem_wdata = rd_data;
  assign alu_op     = alu_op_q;
  assign alu_in0    = alu_in0_q;
  assign alu_in1    = alu_in1_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed program steps plus random instructions vs a reference model.
// Latency: checks 4/5+wait cycles per instruction.
// Backpressure: memory acks delayed by programmable wait counts.
module tb_cpu_ctrl;

  localparam logic [3:0] AND_ = 4'h0, OR_ = 4'h1, ADD_ = 4'h2, SUB_ = 4'h3, CMP_ = 4'h4;
  localparam logic [3:0] ADDI_ = 4'h5, SUBI_ = 4'h6, CMPI_ = 4'h7, LOAD_ = 4'h8, STORE_ = 4'h9;
  localparam logic [3:0] JMP_ = 4'hA, JMPR_ = 4'hB, JNZ_ = 4'hC, LI_ = 4'hD, LTI_ = 4'hE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  alu_op;
  logic [7:0]  alu_in0, alu_in1, alu_out;
  logic        alu_zf;
  logic [7:0]  pc;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic       m_flag;
  logic       m_halt;
  logic [7:0] ref_mem  [256];
  logic [7:0] dmem_arr [256];

  always #5 clk = ~clk;

  cpu_ctrl #(.PC_RESET(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out), .alu_zf(alu_zf),
    .pc(pc), .halted(halted)
  );

  // External alu stage: compares give 1 for true, zf reports a nonzero result
  always_comb begin
    case (alu_op)
      AND_:              alu_out = alu_in0 & alu_in1;
      OR_:               alu_out = alu_in0 | alu_in1;
      ADD_, ADDI_, LOAD_, STORE_, JMPR_: alu_out = alu_in0 + alu_in1;
      SUB_, SUBI_:       alu_out = alu_in1 - alu_in0;
      CMP_, CMPI_:       alu_out = {7'd0, alu_in0 == alu_in1};
      LTI_:              alu_out = {7'd0, alu_in0 > alu_in1};
      JMP_, JNZ_, LI_:   alu_out = alu_in0;
      default:           alu_out = 8'h00;
    endcase
    alu_zf = (alu_out != 8'h00);
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00; m_flag = 1'b0; m_halt = 1'b0;
  endtask

  // Architectural effect of one instruction
  task automatic model_exec(input logic [15:0] w);
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm, a, b, addr, npc;
    op = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
    a = m_reg[rd]; b = m_reg[rs]; addr = b + imm; npc = m_pc + 8'd1;
    case (op)
      AND_:   m_reg[rd] = a & b;
      OR_:    m_reg[rd] = a | b;
      ADD_:   m_reg[rd] = a + b;
      SUB_:   m_reg[rd] = a - b;
      CMP_:   begin m_flag = (a == b);   m_reg[rd] = {7'd0, a == b}; end
      ADDI_:  m_reg[rd] = a + imm;
      SUBI_:  m_reg[rd] = a - imm;
      CMPI_:  begin m_flag = (a == imm); m_reg[rd] = {7'd0, a == imm}; end
      LTI_:   begin m_flag = (imm > a);  m_reg[rd] = {7'd0, imm > a}; end
      LOAD_:  m_reg[rd] = ref_mem[addr];
      STORE_: ref_mem[addr] = a;
      JMP_:   npc = imm;
      JMPR_:  npc = m_pc + imm;
      JNZ_:   if (m_flag) npc = imm;
      LI_:    m_reg[rd] = imm;
      default: begin m_halt = 1'b1; npc = m_pc; end
    endcase
    m_pc = npc;
  endtask

  // Fetch one instruction, serve its data access after dwait stall cycles, then compare state
  task automatic run_instr(input logic [15:0] w, input int dwait);
    int t, cyc, wc, exp_lat;
    bit saw_mem, done, is_mem;
    logic [7:0] e_addr, e_wd;
    logic e_we;
    is_mem = (w[15:12] == LOAD_) || (w[15:12] == STORE_);
    e_addr = m_reg[w[9:8]] + w[7:0];
    e_wd   = m_reg[w[11:10]];
    e_we   = (w[15:12] == STORE_);
    exp_lat = (w[15:12] == 4'hF) ? 2 : (is_mem ? 5 + dwait : 4);
    t = 0;
    while (!imem_req && t < 20) begin @(negedge clk); t++; end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, m_pc);
    imem_data = w; imem_ack = 1'b1;
    cyc = 0; wc = 0; saw_mem = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      if (imem_req || halted) begin
        done = 1;
      end else if (dmem_req) begin
        saw_mem = 1;
        chk("mem_we", dmem_we, e_we);
        chk("mem_addr", dmem_addr, e_addr);
        chk("mem_wdata", dmem_wdata, e_wd);
        if (wc == dwait) begin
          dmem_ack = 1'b1;
          if (dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
          else         dmem_rdata = dmem_arr[dmem_addr];
        end else begin
          wc++;
        end
      end
    end
    model_exec(w);
    chk("latency", cyc[15:0], exp_lat[15:0]);
    chk("mem_used", saw_mem, is_mem);
    chk("pc", pc, m_pc);
    chk("halted", halted, m_halt);
    chk("flag", u_dut.flag_q, m_flag);
    for (int i = 0; i < 4; i++) chk("reg", u_dut.u_regfile.regs_q[i], m_reg[i]);
  endtask

  initial begin
    int t;
    logic [15:0] w;
    logic [3:0] op;
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0; dmem_ack = 1'b0; dmem_rdata = 8'h0;
    for (int i = 0; i < 256; i++) begin
      dmem_arr[i] = 8'($urandom);
      ref_mem[i]  = dmem_arr[i];
    end
    model_reset();

    // reset held two cycles
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_alu", {alu_op, alu_in0}, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 8'h00);

    // arithmetic
    run_instr(mk(LI_, 1, 0, 8'd5), 0);
    run_instr(mk(LI_, 2, 0, 8'd3), 0);
    run_instr(mk(SUB_, 1, 2, 8'd0), 0);
    chk("sub_r1", u_dut.u_regfile.regs_q[1], 8'h02);
    run_instr(mk(ADD_, 1, 2, 8'd0), 0);
    chk("add_r1", u_dut.u_regfile.regs_q[1], 8'h05);

    // store then load with three wait cycles
    run_instr(mk(LI_, 0, 0, 8'h10), 0);
    run_instr(mk(STORE_, 0, 3, 8'h20), 0);
    run_instr(mk(LOAD_, 2, 3, 8'h20), 3);
    chk("load_r2", u_dut.u_regfile.regs_q[2], 8'h10);

    // compare and conditional jump, taken then not taken
    run_instr(mk(LI_, 1, 0, 8'd7), 0);
    run_instr(mk(CMPI_, 1, 0, 8'd7), 0);
    chk("cmpi_eq_flag", u_dut.flag_q, 1'b1);
    run_instr(mk(JNZ_, 0, 0, 8'h40), 0);
    chk("jnz_taken", pc, 8'h40);
    run_instr(mk(LI_, 1, 0, 8'd7), 0);
    run_instr(mk(CMPI_, 1, 0, 8'd8), 0);
    chk("cmpi_ne_flag", u_dut.flag_q, 1'b0);
    run_instr(mk(JNZ_, 0, 0, 8'h40), 0);
    chk("jnz_not_taken", pc, 8'h43);

    // pc wrap cases
    run_instr(mk(JMP_, 0, 0, 8'hFE), 0);
    run_instr(mk(JMPR_, 0, 0, 8'h05), 0);
    chk("jmpr_wrap", pc, 8'h03);
    run_instr(mk(JMP_, 0, 0, 8'hFF), 0);
    run_instr(mk(JMP_, 0, 0, 8'h00), 0);
    chk("jmp_from_ff", pc, 8'h00);
    run_instr(mk(JMP_, 0, 0, 8'hFF), 1);
    run_instr(mk(LI_, 3, 0, 8'h99), 0);
    chk("inc_wrap", pc, 8'h00);

    // random instruction stream
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 14));
      w  = mk(op, 2'($urandom), 2'($urandom), 8'($urandom));
      if ((op == CMPI_ || op == LTI_) && $urandom_range(0, 1) == 1) w[7:0] = m_reg[w[11:10]];
      run_instr(w, int'($urandom_range(0, 3)));
    end

    // undefined opcode halts; no further fetches
    run_instr(16'hF123, 0);
    t = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || dmem_req) t++;
    end
    chk("halt_no_req", t[15:0], 16'd0);
    chk("halt_sticky", halted, 1'b1);

    // reset exits halt; then reset during a stalled load
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    model_reset();
    chk("rst_halt_clr", halted, 1'b0);
    t = 0;
    while (!imem_req && t < 20) begin @(negedge clk); t++; end
    imem_data = mk(LOAD_, 2, 0, 8'h20); imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    t = 0;
    while (!dmem_req && t < 20) begin @(negedge clk); t++; end
    chk("mid_mem_req", dmem_req, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("mid_mem_hold", {dmem_req, dmem_we, dmem_addr}, {2'b10, 8'h20});
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_dmem_req", dmem_req, 1'b0);
    chk("rst_mid_imem_req", imem_req, 1'b0);
    chk("rst_mid_pc", pc, 8'h00);
    dmem_ack = 1'b1; dmem_rdata = 8'hA5;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    run_instr(mk(LI_, 3, 0, 8'h5A), 0);
    run_instr(mk(ADDI_, 3, 0, 8'h01), 2);
    chk("after_rst_r3", u_dut.u_regfile.regs_q[3], 8'h5B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
